// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters, an early pixel
// request window for a fixed-latency source, and aligned sync/de/video outputs.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          HSYNC_POL  = 1'b0,
    parameter bit          VSYNC_POL  = 1'b0,
    parameter int unsigned PIPE_STAGE = 2,
    parameter int unsigned COLOR_W    = 12
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               pixEn,
    input  logic [COLOR_W-1:0] videoIn,
    output logic [10:0]        hAddr,
    output logic [9:0]         vAddr,
    output logic               videoOn,
    output logic               frameStart,
    output logic               lineStart,
    output logic               hSync,
    output logic               vSync,
    output logic               de,
    output logic [COLOR_W-1:0] videoOut
);

    localparam int unsigned H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned H_ACT_START = H_SYNC + H_BP;
    localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE;
    localparam int unsigned V_ACT_START = V_SYNC + V_BP;
    localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE;

    // Reset image of a sync delay line: inner stages hold line-0 positions
    // 1..PIPE_STAGE-1 so the first sync pulse starts on the first enabled cycle.
    function automatic logic [PIPE_STAGE-1:0] sync_preset(input bit pol, input int unsigned span);
        logic [PIPE_STAGE-1:0] img;
        bit                    lvl;
        img = '0;
        for (int unsigned k = 0; k < PIPE_STAGE; k++) begin
            lvl = ((k < PIPE_STAGE - 1) && ((PIPE_STAGE - 1 - k) < span)) ? pol : !pol;
            if (lvl) img = img | (PIPE_STAGE'(1) << k);
        end
        return img;
    endfunction

    localparam logic [PIPE_STAGE-1:0] HS_PRESET = sync_preset(HSYNC_POL, H_SYNC);
    localparam logic [PIPE_STAGE-1:0] VS_PRESET = sync_preset(VSYNC_POL, H_TOTAL);

    logic [10:0]           h_cnt;
    logic [9:0]            v_cnt;
    logic                  h_last;
    logic                  v_last;
    logic [11:0]           h_sum;
    logic [10:0]           h_look;
    logic [9:0]            v_look;
    logic                  h_act;
    logic                  v_act;
    logic                  hs_raw;
    logic                  vs_raw;
    logic [PIPE_STAGE-1:0] req_sr;
    logic [PIPE_STAGE-1:0] hs_sr;
    logic [PIPE_STAGE-1:0] vs_sr;
    logic [PIPE_STAGE-1:0] req_next;
    logic [PIPE_STAGE-1:0] hs_next;
    logic [PIPE_STAGE-1:0] vs_next;
    logic                  line_start_q;
    logic                  frame_start_q;
    logic [COLOR_W-1:0]    video_q;

    assign h_last = (h_cnt == 11'(H_TOTAL - 1));
    assign v_last = (v_cnt == 10'(V_TOTAL - 1));

    // Raster position the outputs will show once this request leaves the pipe.
    always_comb begin : lookahead
        h_sum  = 12'(h_cnt) + 12'(PIPE_STAGE);
        h_look = 11'(h_sum);
        v_look = v_cnt;
        if (h_sum >= 12'(H_TOTAL)) begin
            h_look = 11'(h_sum - 12'(H_TOTAL));
            v_look = v_last ? '0 : v_cnt + 10'd1;
        end
    end

    always_comb begin : request
        h_act   = (h_look >= 11'(H_ACT_START)) && (h_look < 11'(H_ACT_END));
        v_act   = (v_look >= 10'(V_ACT_START)) && (v_look < 10'(V_ACT_END));
        videoOn = h_act && v_act;
        hAddr   = '0;
        vAddr   = '0;
        if (videoOn) begin
            hAddr = h_look - 11'(H_ACT_START);
            vAddr = v_look - 10'(V_ACT_START);
        end
        hs_raw = (h_look < 11'(H_SYNC)) ? HSYNC_POL : !HSYNC_POL;
        vs_raw = (v_look < 10'(V_SYNC)) ? VSYNC_POL : !VSYNC_POL;
    end

    // Delay-line inputs; the top stage of each shifted vector is the tap one
    // cycle ahead of the output register.
    assign req_next = PIPE_STAGE'({req_sr, videoOn});
    assign hs_next  = PIPE_STAGE'({hs_sr, hs_raw});
    assign vs_next  = PIPE_STAGE'({vs_sr, vs_raw});

    always_ff @(posedge clk or negedge rstn) begin : counters
        if (!rstn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pixEn) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin : out_pipe
        if (!rstn) begin
            req_sr        <= '0;
            hs_sr         <= HS_PRESET;
            vs_sr         <= VS_PRESET;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            video_q       <= '0;
        end else if (pixEn) begin
            req_sr        <= req_next;
            hs_sr         <= hs_next;
            vs_sr         <= vs_next;
            line_start_q  <= h_last;
            frame_start_q <= h_last && v_last;
            video_q       <= req_next[PIPE_STAGE-1] ? videoIn : '0;
        end
    end

    assign de         = req_sr[PIPE_STAGE-1];
    assign hSync      = hs_sr[PIPE_STAGE-1];
    assign vSync      = vs_sr[PIPE_STAGE-1];
    assign lineStart  = line_start_q;
    assign frameStart = frame_start_q;
    assign videoOut   = video_q;

endmodule
